// File: rtl/fp_accum.sv
// Frame accumulator for the 27-bit float format: sums the operands of each frame
// through an external one-cycle adder and presents the total with its operand count.
module fp_accum #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [26:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [26:0]      add_in1,
    output logic [26:0]      add_in2,
    input  logic [26:0]      add_sum,
    output logic             out_valid,
    output logic [26:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready,
    output logic [1:0]       state_dbg
);

    // Handshake: an operand moves on a rising edge where in_valid && in_ready;
    // a result is held on out_valid until a rising edge with out_ready high.
    typedef enum logic [1:0] {EMPTY, ACC, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [26:0]       acc;
    logic [CNT_W-1:0]  cnt;
    logic              last_q;
    logic              run_q;
    logic              xfer;

    // run_q keeps in_ready low until the first edge after reset is released.
    assign in_ready  = run_q && (state == EMPTY || state == ACC);
    assign xfer      = in_valid && in_ready;
    assign add_in1   = acc;
    assign add_in2   = in_data;
    assign out_data  = acc;
    assign out_count = cnt;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        case (state)
            EMPTY: if (xfer) state_nxt = in_last ? DONE : ACC;
            ACC:   if (xfer) state_nxt = WAIT;
            WAIT:  state_nxt = last_q ? DONE : ACC;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            acc    <= '0;
            cnt    <= '0;
            last_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            state <= state_nxt;
            case (state)
                EMPTY: if (xfer) begin
                    acc <= in_data;
                    cnt <= CNT_W'(1);
                end
                ACC: if (xfer) last_q <= in_last;
                WAIT: begin
                    // add_sum is taken verbatim; no special-value handling here.
                    acc <= add_sum;
                    if (cnt != '1) cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: a behavioural one-cycle float adder, a result
// scoreboard, and a wide-count plus a 2-bit-count instance fed the same stimulus.
module tb_fp_accum;

    localparam int EW = 27 + 16;
    localparam logic [26:0] ONE   = 27'h1FC0000;
    localparam logic [26:0] TWO   = 27'h2000000;
    localparam logic [26:0] THREE = 27'h2020000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [26:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [26:0] add_in1, add_in2, out_data;
    logic [26:0] add_sum = '0;
    logic [7:0]  out_count;
    logic [1:0]  state_dbg;

    logic        s_in_ready, s_out_valid;
    logic [26:0] s_add_in1, s_add_in2, s_out_data;
    logic [26:0] s_add_sum = '0;
    logic [1:0]  s_out_count;
    logic [1:0]  s_state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    fp_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .add_in1(add_in1), .add_in2(add_in2), .add_sum(add_sum),
        .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
        .out_ready(out_ready), .state_dbg(state_dbg)
    );

    fp_accum #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(s_in_ready), .add_in1(s_add_in1), .add_in2(s_add_in2), .add_sum(s_add_sum),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_count(s_out_count),
        .out_ready(out_ready), .state_dbg(s_state_dbg)
    );

    // ---------------- clock / reference adder ----------------
    always #5 clk = ~clk;

    // Positive-operand float add, truncating the aligned smaller mantissa.
    function automatic logic [26:0] fp_add(input logic [26:0] a, input logic [26:0] b);
        logic [26:0] hi, lo;
        logic [18:0] mh, ml;
        logic [19:0] s;
        logic [7:0]  e, d;
        if (a[25:18] >= b[25:18]) begin hi = a; lo = b; end
        else begin hi = b; lo = a; end
        d  = hi[25:18] - lo[25:18];
        mh = {1'b1, hi[17:0]};
        ml = (d > 8'd19) ? 19'd0 : ({1'b1, lo[17:0]} >> d);
        s  = {1'b0, mh} + {1'b0, ml};
        e  = hi[25:18];
        if (s[19]) begin
            s = s >> 1;
            e = e + 8'd1;
        end
        return {1'b0, e, s[17:0]};
    endfunction

    always @(posedge clk) begin
        add_sum   <= fp_add(add_in1, add_in2);
        s_add_sum <= fp_add(s_add_in1, s_add_in2);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"},  32'(out_data), 0);
        check({tag, "_out_count"}, 32'(out_count), 0);
        check({tag, "_in_ready"},  32'(in_ready), 0);
        check({tag, "_state"},     32'(state_dbg), 0);
        check({tag, "_sat_valid"}, 32'(s_out_valid), 0);
        check({tag, "_sat_count"}, 32'(s_out_count), 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_op(input logic [26:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int hold);
        int t = 0;
        logic [EW-1:0] e;
        logic [26:0]   held;
        int            c, cs;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_timeout", 32'(out_valid), 1);
        check("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            c  = int'(e[15:0]);
            cs = (c > 3) ? 3 : c;
            check("out_data",  32'(out_data), 32'(e[EW-1:16]));
            check("out_count", 32'(out_count), 32'(c));
            check("sat_data",  32'(s_out_data), 32'(e[EW-1:16]));
            check("sat_count", 32'(s_out_count), 32'(cs));
            check("sat_valid", 32'(s_out_valid), 1);
        end
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data",  32'(out_data), 32'(held));
            check("hold_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_state", 32'(state_dbg), 0);
        check("release_valid", 32'(out_valid), 0);
        check("release_ready", 32'(in_ready), 1);
    endtask

    task automatic send_frame(input int n, input logic [26:0] d, input logic [26:0] exp_sum,
                              input int hold);
        exp_q.push_back({exp_sum, 16'(n)});
        for (int i = 0; i < n; i++) begin
            send_op(d, i == n - 1);
            if (i == 0 && n > 1) begin
                check("first_acc_ready", 32'(in_ready), 1);
                check("first_acc_valid", 32'(out_valid), 0);
            end else begin
                check("wait_done_ready", 32'(in_ready), 0);
            end
            if (n == 1) check("single_latency", 32'(out_valid), 1);
        end
        collect(hold);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [26:0] d, sum;
        int          n;

        #1 rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("ready_before_edge", 32'(in_ready), 0);
        @(posedge clk);
        #1 check("ready_after_edge", 32'(in_ready), 1);
        check("state_after_reset", 32'(state_dbg), 0);

        // in_last without in_valid must not start or close anything
        in_last = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_last_state", 32'(state_dbg), 0);
        check("idle_last_valid", 32'(out_valid), 0);
        in_last = 1'b0;

        send_frame(1, ONE, ONE, 0);
        send_frame(2, ONE, TWO, 0);
        send_frame(3, ONE, THREE, 0);
        send_frame(2, ONE, TWO, 5);

        // five 1.0 operands: wide count reaches 5, 2-bit count sticks at 3
        sum = ONE;
        for (int i = 1; i < 5; i++) sum = fp_add(sum, ONE);
        send_frame(5, ONE, sum, 0);

        // ACC holds while in_valid is low, even with in_last toggling
        exp_q.push_back({THREE, 16'd2});
        send_op(TWO, 1'b0);
        in_last = 1'b1;
        repeat (4) @(negedge clk);
        check("acc_hold_state", 32'(state_dbg), 1);
        check("acc_hold_data",  32'(out_data), 32'(TWO));
        check("acc_hold_ready", 32'(in_ready), 1);
        in_last = 1'b0;
        send_op(ONE, 1'b1);
        collect(1);

        for (int f = 0; f < 3; f++) begin
            d = {1'b0, 8'($urandom_range(120, 134)), 18'($urandom_range(0, 18'h3FFFF))};
            n = $urandom_range(2, 6);
            sum = d;
            for (int i = 1; i < n; i++) sum = fp_add(sum, d);
            send_frame(n, d, sum, $urandom_range(0, 3));
        end

        // reset while WAIT is pending discards the partial sum
        send_op(ONE, 1'b0);
        send_op(ONE, 1'b0);
        check("pre_reset_wait", 32'(state_dbg), 2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_midframe");
        @(posedge clk);
        #1 check_reset_outputs("reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("ready_after_midreset", 32'(in_ready), 1);
        send_frame(1, TWO, TWO, 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_accum.md
FP_ACCUM -- requirements
Module: fp_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the operand counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand present on in_data.
REQ-005 SHALL have port in_data  input  27  operand in the 27-bit float format: [26] sign, [25:18] exponent excess-127, [17:0] mantissa with hidden 1.
REQ-006 SHALL have port in_last  input  1  qualifies in_data as the final operand of a frame.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port add_in1  output  27  first operand to the external 27-bit adder.
REQ-009 SHALL have port add_in2  output  27  second operand to the external 27-bit adder.
REQ-010 SHALL have port add_sum  input  27  result from the external adder; valid one clock after its operands were sampled.
REQ-011 SHALL have port out_valid  output  1  frame result available.
REQ-012 SHALL have port out_data  output  27  accumulated frame sum.
REQ-013 SHALL have port out_count  output  CNT_W  number of operands summed into out_data.
REQ-014 SHALL have port out_ready  input  1  downstream consumes the result.

Function
REQ-015 SHALL implement four states: EMPTY, ACC, WAIT, DONE.
REQ-016 SHALL hold internal registers acc[26:0], cnt[CNT_W-1:0] and last_q.
REQ-017 SHALL transfer an operand only when in_valid and in_ready are both high at a rising edge.
REQ-018 SHALL drive add_in1 = acc and add_in2 = in_data combinationally in every state.
REQ-019 EMPTY: in_ready=1; on transfer: acc<=in_data, cnt<=1; next state DONE if in_last, else ACC.
REQ-020 ACC: in_ready=1; on transfer: last_q<=in_last, next state WAIT; the adder samples acc and in_data on this same edge.
REQ-021 WAIT: in_ready=0; acc<=add_sum, cnt<=cnt+1 (saturating at 2^CNT_W-1); next state DONE if last_q, else ACC.
REQ-022 DONE: in_ready=0, out_valid=1, out_data=acc, out_count=cnt; on out_ready high, next state EMPTY.
REQ-023 out_valid SHALL be 0 in every state except DONE; out_data and out_count SHALL hold stable while out_valid=1.
REQ-024 Latency SHALL be 1 cycle for a 1-operand frame (transfer edge to out_valid high) and 2N-1 cycles for N operands with in_valid held high.
REQ-025 Throughput in a frame SHALL be one operand per 2 cycles after the first.
REQ-026 In ACC, in_valid low SHALL hold state and acc indefinitely.
REQ-027 cnt SHALL saturate at 2^CNT_W-1 and never wrap to 0; accumulation continues with no other effect.
REQ-028 The block SHALL NOT check operands for zero, denormal, exponent overflow or underflow; add_sum is captured verbatim.
REQ-029 in_last is sampled only on a transfer; in_last with in_valid low SHALL be ignored.

Reset
REQ-030 While rst is high, the block SHALL force state=EMPTY, acc=0, cnt=0, last_q=0, out_valid=0, out_data=0 and out_count=0 immediately, without waiting for clk.
REQ-031 While rst is high, in_ready SHALL be 0; it SHALL return to 1 on the first clk edge after rst falls.
REQ-032 Reset asserted mid-frame (ACC or WAIT) or during DONE SHALL discard the partial or pending result; the add_sum captured on the next edge is ignored.

Verification
REQ-033 Single operand: send 27'h1FC0000 (1.0) with in_last -> next cycle out_valid=1, out_data=27'h1FC0000, out_count=1.
REQ-034 Two-operand frame: send 27'h1FC0000 then 27'h1FC0000 with in_last -> out_data=27'h2000000 (2.0), out_count=2, out_valid 3 cycles after the first transfer.
REQ-035 Three operands: send 1.0, 1.0, 1.0 with in_last -> out_data=27'h2020000 (3.0), out_count=3; in_ready low in each WAIT cycle.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay stable and in_ready=0; on out_ready=1, EMPTY on the next edge.
REQ-037 Saturation: CNT_W=2, stream 5 operands of 1.0 -> out_count=3.
REQ-038 Reset mid-frame: assert rst in WAIT -> out_valid=0 and acc=0 immediately; a new single-operand frame of 2.0 then yields 27'h2000000 with count 1.
